// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, valid/ack holding register with error pulses.
// Optional even parity (8E1) enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int BAUD_DIVISOR    = CLOCK_FREQUENCY / BAUD_RATE,
  parameter int HALF_DIVISOR    = BAUD_DIVISOR / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       framing_error,
  output logic       parity_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (BAUD_DIVISOR > 2) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_DIVISOR - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state;
  logic           rx_meta;
  logic           rx_s;
  logic           armed;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad <= 1'b0;
    end else if (state == PARITY && cnt == '0) begin
      par_bad <= (rx_s != ^shreg);
    end else if (state == IDLE) begin
      par_bad <= 1'b0;
    end
  end
`else
  assign par_bad      = 1'b0;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      armed         <= 1'b0;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      // ack is applied first so a byte completing on the same edge still loads
      if (ack) valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
            cnt   <= HALF_LOAD;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!rx_s) begin
            state   <= DATA;
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            cnt   <= FULL_LOAD;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            // a low stop bit disarms IDLE so a held break cannot start a new frame
            if (!rx_s) begin
              framing_error <= 1'b1;
              armed         <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            if (par_bad) parity_error <= 1'b1;
`endif
            if (rx_s && !par_bad) begin
              if (valid && !ack) begin
                overrun <= 1'b1;
              end else begin
                data  <= shreg;
                valid <= 1'b1;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected bytes vs bytes seen on valid rising edges.
module tb_uart_rx;

  localparam int DIV = 27000000 / 115200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       parity_error;
  logic       overrun;
  logic       busy;

  uart_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .data          (data),
    .valid         (valid),
    .ack           (ack),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         rd_idx = 0;

  int   fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, wide_cnt = 0;
  logic valid_q = 1'b0, fe_q = 1'b0, pe_q = 1'b0, ov_q = 1'b0;

  // Observation only: records bytes on valid rising edges and counts error pulses.
  always @(negedge clk) begin
    if (valid && !valid_q) got_q.push_back(data);
    if (framing_error) fe_cnt++;
    if (parity_error) pe_cnt++;
    if (overrun) ov_cnt++;
    if ((framing_error && fe_q) || (parity_error && pe_q) || (overrun && ov_q)) wide_cnt++;
    valid_q = valid;
    fe_q    = framing_error;
    pe_q    = parity_error;
    ov_q    = overrun;
  end

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (DIV) @(posedge clk);
`endif
    rx = stop;
    repeat (DIV) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({data, valid, framing_error, parity_error, overrun, busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got data=%h valid=%b fe=%b pe=%b ov=%b busy=%b want all 0",
               data, valid, framing_error, parity_error, overrun, busy);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b valid=%b want 0 0", busy, valid);
    end
  endtask

  task automatic test_basic();
    int fe0 = fe_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, ^8'h55, 1'b1);
    for (int i = 0; i < 3 * DIV && !valid; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid got %b want 1", valid);
    end
    n_checks++;
    if (got_q.size() - rd_idx != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count got %0d want %0d", got_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
      logic [7:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q[rd_idx] !== e) begin
        n_fail++;
        $display("FAIL basic_data got %h want %h", got_q[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    n_checks++;
    if (fe_cnt != fe0 || pe_cnt != 0 || ov_cnt != 0) begin
      n_fail++;
      $display("FAIL basic_errors got fe=%0d pe=%0d ov=%0d want none new", fe_cnt - fe0, pe_cnt, ov_cnt);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ack_clear got valid=%b want 0", valid);
    end
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt;
    int g0  = got_q.size();
    rx = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy got %b want 1", busy);
    end
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || fe_cnt != fe0 || got_q.size() != g0) begin
      n_fail++;
      $display("FAIL glitch_idle got busy=%b valid=%b fe_new=%0d bytes_new=%0d want 0 0 0 0",
               busy, valid, fe_cnt - fe0, got_q.size() - g0);
    end
  endtask

  task automatic test_framing();
    int fe0 = fe_cnt;
    int g0  = got_q.size();
    send_frame(8'hA3, ^8'hA3, 1'b0);
    n_checks++;
    if (fe_cnt != fe0 + 1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_pulse got fe_new=%0d valid=%b want 1 0", fe_cnt - fe0, valid);
    end
    repeat (3 * DIV) @(posedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    n_checks++;
    if (fe_cnt != fe0 + 1 || got_q.size() != g0 || busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_break got fe_new=%0d bytes_new=%0d busy=%b valid=%b want 1 0 0 0",
               fe_cnt - fe0, got_q.size() - g0, busy, valid);
    end
  endtask

  task automatic test_overrun();
    int ov0 = ov_cnt;
    exp_q.push_back(8'h12);
    send_frame(8'h12, ^8'h12, 1'b1);
    send_frame(8'h34, ^8'h34, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (ov_cnt != ov0 + 1 || valid !== 1'b1 || data !== 8'h12) begin
      n_fail++;
      $display("FAIL overrun_hold got ov_new=%0d valid=%b data=%h want 1 1 12", ov_cnt - ov0, valid, data);
    end
    n_checks++;
    if (got_q.size() - rd_idx != exp_q.size()) begin
      n_fail++;
      $display("FAIL overrun_count got %0d want %0d", got_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
      logic [7:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q[rd_idx] !== e) begin
        n_fail++;
        $display("FAIL overrun_data got %h want %h", got_q[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_ack got valid=%b want 0", valid);
    end
  endtask

  task automatic test_back_to_back();
    int timeouts = 0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    fork
      begin
        send_frame(8'hA5, ^8'hA5, 1'b1);
        send_frame(8'h5A, ^8'h5A, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int w = 0;
          while (!valid && w < 12 * DIV) begin
            @(negedge clk);
            w++;
          end
          if (!valid) timeouts++;
          ack = 1'b1;
          @(negedge clk);
          ack = 1'b0;
        end
      end
    join
    n_checks++;
    if (timeouts != 0) begin
      n_fail++;
      $display("FAIL b2b_timeout got %0d timeouts want 0", timeouts);
    end
    n_checks++;
    if (got_q.size() - rd_idx != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want %0d", got_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
      logic [7:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q[rd_idx] !== e) begin
        n_fail++;
        $display("FAIL b2b_data got %h want %h", got_q[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    fork
      send_frame(8'hFF, ^8'hFF, 1'b1);
      begin
        repeat (5 * DIV + DIV / 2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset_state got busy=%b valid=%b want 0 0", busy, valid);
        end
        rst_n = 1'b1;
      end
    join
    repeat (DIV) @(posedge clk);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, ^8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (got_q.size() - rd_idx != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_count got %0d want %0d", got_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
      logic [7:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q[rd_idx] !== e) begin
        n_fail++;
        $display("FAIL midreset_data got %h want %h", got_q[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0 = pe_cnt;
    int g0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (got_q.size() - rd_idx != 1 || valid !== 1'b1 || data !== 8'h07 || pe_cnt != pe0) begin
      n_fail++;
      $display("FAIL parity_good got bytes=%0d valid=%b data=%h pe_new=%0d want 1 1 07 0",
               got_q.size() - rd_idx, valid, data, pe_cnt - pe0);
    end
    rd_idx = got_q.size();
    exp_q.delete();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    g0 = got_q.size();
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (pe_cnt != pe0 + 1 || valid !== 1'b0 || got_q.size() != g0) begin
      n_fail++;
      $display("FAIL parity_bad got pe_new=%0d valid=%b bytes_new=%0d want 1 0 0",
               pe_cnt - pe0, valid, got_q.size() - g0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (wide_cnt != 0) begin
      n_fail++;
      $display("FAIL pulse_width got %0d wide pulses want 0", wide_cnt);
    end
    n_checks++;
    if (got_q.size() != rd_idx) begin
      n_fail++;
      $display("FAIL unexpected_bytes got %0d unconsumed want 0", got_q.size() - rd_idx);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
